// File: rtl/sw_pkg.sv
// Shared types and default sizes for the switch ingress buffer.
package sw_pkg;

  localparam int SW_DATA_W  = 8;
  localparam int SW_DEPTH   = 64;
  localparam int SW_MAX_PKT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } sw_state_e;

  typedef struct packed {
    logic [SW_DATA_W-1:0] data;
    logic                 last;
  } sw_entry_t;

endpackage

// File: rtl/sw_fifo_mem.sv
// Packet FIFO storage: synchronous write, asynchronous (fall-through) read.
module sw_fifo_mem
  import sw_pkg::*;
#(
  parameter int WIDTH = $bits(sw_entry_t),
  parameter int DEPTH = SW_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sw_ingress_buf.sv
// Switch ingress port: stages framed bytes, commits or drops whole packets.
// Define SW_INGRESS_STATS_EN to add pkt_cnt/drop_cnt saturating counters.
module sw_ingress_buf
  import sw_pkg::*;
#(
  parameter int DATA_W  = SW_DATA_W,
  parameter int DEPTH   = SW_DEPTH,
  parameter int MAX_PKT = SW_MAX_PKT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              sw_enable_in,
  output logic              read_out,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              drop_o
`ifdef SW_INGRESS_STATS_EN
  ,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(MAX_PKT + 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } entry_t;

  sw_state_e         state_q, state_d;
  logic [PW-1:0]     wr_spec_q, wr_spec_d;
  logic [PW-1:0]     wr_cmt_q, wr_cmt_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [LW-1:0]     len_q, len_d;
  logic [DATA_W-1:0] stage_q, stage_d;
  logic              drop_q, drop_d;
  logic              busy_q, busy_d;
  logic              full, pop, we;
  logic [PW-1:0]     used;
  logic [PW:0]       free;
  entry_t            wentry, rentry;

  assign full = ((wr_spec_q ^ rd_q) == {1'b1, {AW{1'b0}}});

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_spec_q <= '0;
      wr_cmt_q  <= '0;
      rd_q      <= '0;
      len_q     <= '0;
      stage_q   <= '0;
      drop_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_spec_q <= wr_spec_d;
      wr_cmt_q  <= wr_cmt_d;
      rd_q      <= rd_d;
      len_q     <= len_d;
      stage_q   <= stage_d;
      drop_q    <= drop_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (sw_enable_in) state_d = RECV;
      RECV: begin
        if (sw_enable_in) begin
          if (len_q == LW'(MAX_PKT) || full) state_d = DROP;
        end else begin
          state_d = IDLE;
        end
      end
      DROP:    if (!sw_enable_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we        = 1'b0;
    wentry    = '{data: stage_q, last: 1'b0};
    wr_spec_d = wr_spec_q;
    wr_cmt_d  = wr_cmt_q;
    len_d     = len_q;
    stage_d   = stage_q;
    drop_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sw_enable_in) begin
          stage_d = data_in;
          len_d   = LW'(1);
        end
      end
      RECV: begin
        if (sw_enable_in) begin
          if (len_q == LW'(MAX_PKT) || full) begin
            wr_spec_d = wr_cmt_q;
          end else begin
            we        = 1'b1;
            wr_spec_d = wr_spec_q + PW'(1);
            stage_d   = data_in;
            len_d     = len_q + LW'(1);
          end
        end else if (full) begin
          // No room for the final byte (upstream ignored busy): discard rather than overwrite.
          wr_spec_d = wr_cmt_q;
          drop_d    = 1'b1;
        end else begin
          we          = 1'b1;
          wentry.last = 1'b1;
          wr_spec_d   = wr_spec_q + PW'(1);
          wr_cmt_d    = wr_spec_q + PW'(1);
        end
      end
      DROP:    if (!sw_enable_in) drop_d = 1'b1;
      default: ;
    endcase
  end

  sw_fifo_mem #(
    .WIDTH($bits(entry_t)),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk    (clk),
    .we_i   (we),
    .waddr_i(wr_spec_q[AW-1:0]),
    .wdata_i(wentry),
    .raddr_i(rd_q[AW-1:0]),
    .rdata_o(rentry)
  );

  // Output side only ever sees data up to the committed pointer
  assign out_valid = (rd_q != wr_cmt_q);
  assign pop       = out_valid & out_ready;
  assign rd_d      = rd_q + PW'(pop);
  assign out_data  = out_valid ? rentry.data : '0;
  assign out_last  = out_valid & rentry.last;
  assign drop_o    = drop_q;

  assign used     = wr_cmt_q - rd_q;
  assign free     = (PW+1)'(DEPTH) - {1'b0, used};
  assign busy_d   = (free < (PW+1)'(MAX_PKT));
  assign read_out = busy_q;

`ifdef SW_INGRESS_STATS_EN
  logic        commit;
  logic [15:0] pkt_cnt_q, drop_cnt_q;

  assign commit = (state_q == RECV) && !sw_enable_in && !full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (commit && pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= pkt_cnt_q + 16'd1;
      if (drop_d && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: doc/sw_ingress_buf.md
Name: sw_ingress_buf

Overview:
- Parametrised next-generation switch ingress port.
- Accepts a framed byte stream: data_in is valid while sw_enable_in is high, and a packet ends when sw_enable_in falls.
- Buffers whole packets in a FIFO and commits or drops each packet atomically.
- Presents committed packets on a valid/ready output with a last-byte marker; read_out is the back-pressure "busy" flag to the upstream driver.

Parameters:
- DATA_W, 8: width of data_in and out_data.
- DEPTH, 64: FIFO entries; power of 2, at least 4.
- MAX_PKT, 16: maximum packet length in bytes; 1 ≤ MAX_PKT ≤ DEPTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  DATA_W  packet byte, sampled while sw_enable_in=1.
- sw_enable_in  input  1  frame enable; high for the duration of a packet.
- read_out  output  1  busy: upstream must not start a new packet while high.
- out_data  output  DATA_W  head byte of committed data.
- out_valid  output  1  committed byte available.
- out_last  output  1  head byte is the last byte of its packet.
- out_ready  input  1  consumer accepts; a pop occurs when out_valid & out_ready.
- drop_o  output  1  one-cycle pulse: the packet just ended was discarded.

Behaviour:
- Reset (async, active-low): all pointers = 0, FSM = IDLE, staging register empty. read_out=0, out_valid=0, out_last=0, out_data=0, drop_o=0.
- Pointers are log2(DEPTH)+1 bits with a wrap bit:
  - wr_spec: speculative write pointer.
  - wr_cmt: committed write pointer.
  - rd: read pointer.
  - full is detected when wr_spec and rd differ only in the MSB.
- Staging: each sampled byte is held in a one-entry register. It is written to memory (last=0) when the next byte arrives, or with last=1 when sw_enable_in is sampled low. Each memory entry is DATA_W+1 bits wide.
- Write FSM:
  - IDLE: sw_enable_in=1 → RECV; stage byte; len=1.
  - RECV, sw_enable_in=1: if len==MAX_PKT or the FIFO is full → DROP and wr_spec:=wr_cmt. Otherwise flush the staged byte, stage the new byte, len++.
  - RECV, sw_enable_in=0: write the staged byte with last=1; wr_cmt:=wr_spec+1 on the same edge → IDLE.
  - DROP: discard bytes while sw_enable_in=1. When sw_enable_in=0: drop_o=1 for one cycle → IDLE.
- Packet boundaries: back-to-back packets require at least one low cycle of sw_enable_in between them. A rising edge in the same cycle as the commit is not possible under this rule.
- Latency: if sw_enable_in is sampled low at edge E, the packet is committed at E and out_valid is high in the cycle following E. Minimum latency from the first byte to out_valid is len+1 cycles.
- Output side:
  - out_valid = (rd != wr_cmt). out_data/out_last come from the first-word-fall-through memory at rd.
  - rd increments on each pop. Uncommitted and dropped bytes are never visible at the output.
- read_out is registered: next value = (DEPTH − (wr_cmt − rd)) < MAX_PKT. It may assert mid-packet; the upstream honours it only at packet start.
- Simultaneous pop and write: both occur. The full check uses the pre-edge rd (conservative).
- Wrap-around: pointers wrap modulo 2·DEPTH; the memory is addressed by the low bits.
- Reset mid-packet: the partial packet is lost and committed data is cleared.

Optional Feature:
- SW_INGRESS_STATS_EN defined:
  - Adds outputs pkt_cnt[15:0] (committed packets) and drop_cnt[15:0] (dropped packets).
  - Both are saturating counters, reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package sw_pkg:
  - ingress FSM state enum (IDLE, RECV, DROP);
  - sw_entry_t typedef (data, last);
  - default-width localparams shared with the testbench interfaces.
- Sub-module sw_fifo_mem: dual-port array with synchronous write and asynchronous read, parametrised by width and depth, holding sw_entry_t.

Test Plan:
- Single packet 0xA1,0xB2,0xC3 with out_ready=1 → out_valid rises 4 cycles after the first byte; outputs A1/0, B2/0, C3/1; drop_o stays 0.
- One-byte packet 0x5A → a single entry with out_last=1, emitted the cycle after sw_enable_in falls.
- Oversize 17-byte packet (MAX_PKT=16) → drop_o pulses once; out_valid stays 0; the next 2-byte packet passes intact.
- out_ready=0, four 16-byte packets into DEPTH=64 → read_out=1 after the fourth commit (free=0 < 16). A fifth packet is sent anyway → it is dropped, and the prior 64 bytes drain in order.
- Assert rst_n low mid-packet after 5 bytes → all outputs return to reset values immediately; a post-reset packet is delivered correctly.
- Run 200 random packets of length 1–16 with random out_ready → the scoreboard matches every committed packet byte-for-byte; the pointers wrap at least 10 times.
